ram_dp_bytewr: RTL

//  Parametrised dual-port RAM with per-byte-lane writes, for playfield, motion-object and colour RAMs.

---
 rtl/ram_dp_bytewr_if.sv | 32 +++
 rtl/ram_dp_bytewr.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ram_dp_bytewr_if.sv
// Port bundle for ram_dp_bytewr: CPU read/write port A, scan-out read port B, clear control.
// The master modport drives addresses/strobes; the slave modport is the RAM.
interface ram_dp_bytewr_if #(
  parameter int AW = 10,
  parameter int DW = 16
);
  localparam int NB = DW / 8;

  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_di;
  logic          a_rd;
  logic [NB-1:0] a_be;
  logic [DW-1:0] a_do;

  logic [AW-1:0] b_addr;
  logic          b_rd;
  logic [DW-1:0] b_do;
  logic          b_valid;

  logic          clr_req;
  logic          clr_busy;

  modport master (
    output a_addr, a_di, a_rd, a_be, b_addr, b_rd, clr_req,
    input  a_do, b_do, b_valid, clr_busy
  );

  modport slave (
    input  a_addr, a_di, a_rd, a_be, b_addr, b_rd, clr_req,
    output a_do, b_do, b_valid, clr_busy
  );
endinterface

// File: rtl/ram_dp_bytewr.sv
// Dual-port byte-lane RAM: port A read latency 1, port B read latency 1+B_PIPE, plus a whole-array clear engine.
// No backpressure: every strobe is taken each cycle; port A writes are dropped while clr_busy is high.
module ram_dp_bytewr #(
  parameter int              AW         = 10,
  parameter int              DW         = 16,
  parameter int              B_PIPE     = 0,
  parameter int              RDW_NEW    = 1,
  parameter int              CLR_ON_RST = 1,
  parameter logic [DW-1:0]   CLR_VAL    = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  ram_dp_bytewr_if.slave     bus
);

  localparam int            NB        = DW / 8;
  localparam int            DEPTH     = 1 << AW;
  localparam logic [AW-1:0] LAST_ADDR = '1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam state_t RST_STATE = (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

  logic [DW-1:0] r_mem [DEPTH];

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_nxt;
  logic          w_busy;

  logic [NB-1:0] w_wbe;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdat;

  logic          w_a_hit;
  logic          w_b_hit;
  logic [DW-1:0] w_a_rdat;
  logic [DW-1:0] w_b_rdat;

  logic [DW-1:0] r_a_do;
  logic [DW-1:0] r_b_do;
  logic          r_b_vld;

  // Lanes enabled by the current write take the new byte when the read hits the write address.
  function automatic logic [DW-1:0] f_rdw(
    input logic [DW-1:0] old_dat,
    input logic          hit,
    input logic [NB-1:0] be,
    input logic [DW-1:0] new_dat
  );
    logic [DW-1:0] res;
    res = old_dat;
    for (int i = 0; i < NB; i++) begin
      if (hit && be[i]) begin
        res[8*i +: 8] = new_dat[8*i +: 8];
      end
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (bus.clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        // Counter parks on the top word; clr_req is not looked at here.
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + AW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_busy = (r_state == ST_CLEAR);

  // The clear engine owns the single write path while busy.
  always_comb begin
    w_wbe   = bus.a_be;
    w_waddr = bus.a_addr;
    w_wdat  = bus.a_di;
    if (w_busy) begin
      w_wbe   = '1;
      w_waddr = r_cnt;
      w_wdat  = CLR_VAL;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (w_wbe[i]) begin
        r_mem[w_waddr][8*i +: 8] <= w_wdat[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_a_hit  = (RDW_NEW != 0) && (w_waddr == bus.a_addr);
    w_b_hit  = (RDW_NEW != 0) && (w_waddr == bus.b_addr);
    w_a_rdat = f_rdw(r_mem[bus.a_addr], w_a_hit, w_wbe, w_wdat);
    w_b_rdat = f_rdw(r_mem[bus.b_addr], w_b_hit, w_wbe, w_wdat);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_do <= '0;
    end else if (bus.a_rd) begin
      r_a_do <= w_a_rdat;
    end
  end

  generate
    if (B_PIPE != 0) begin : g_b_pipe
      logic [DW-1:0] r_b_stg;
      logic          r_b_stg_vld;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_b_stg     <= '0;
          r_b_stg_vld <= 1'b0;
          r_b_do      <= '0;
          r_b_vld     <= 1'b0;
        end else begin
          r_b_stg_vld <= bus.b_rd;
          r_b_vld     <= r_b_stg_vld;
          if (bus.b_rd) begin
            r_b_stg <= w_b_rdat;
          end
          if (r_b_stg_vld) begin
            r_b_do <= r_b_stg;
          end
        end
      end
    end else begin : g_b_direct
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_b_do  <= '0;
          r_b_vld <= 1'b0;
        end else begin
          r_b_vld <= bus.b_rd;
          if (bus.b_rd) begin
            r_b_do <= w_b_rdat;
          end
        end
      end
    end
  endgenerate

  assign bus.a_do     = r_a_do;
  assign bus.b_do     = r_b_do;
  assign bus.b_valid  = r_b_vld;
  assign bus.clr_busy = w_busy;

endmodule
